// File: rtl/pov_loader.sv
// pov_loader: SPI-staged point-of-view registers committed to the active set on a frame strobe
module pov_loader #(
  parameter int W = 16,
  parameter logic [W-1:0] RST_PX = 16'h0600,
  parameter logic [W-1:0] RST_PY = 16'h0600,
  parameter logic [W-1:0] RST_FX = 16'h0400,
  parameter logic [W-1:0] RST_FY = 16'h0000,
  parameter logic [W-1:0] RST_VX = 16'h0000,
  parameter logic [W-1:0] RST_VY = 16'hFE00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ss_n,
  input  logic         i_sclk,
  input  logic         i_mosi,
  input  logic         i_load,
  output logic [W-1:0] o_px,
  output logic [W-1:0] o_py,
  output logic [W-1:0] o_fx,
  output logic [W-1:0] o_fy,
  output logic [W-1:0] o_vx,
  output logic [W-1:0] o_vy,
  output logic         o_pending,
  output logic         o_loaded,
  output logic         o_err
);
  localparam int N = 6 * W;
  localparam logic [6:0] FULL = 7'(N);
  localparam logic [6:0] SAT = 7'(N + 1);
  logic [1:0] r_ss_s, r_sclk_s, r_mosi_s, r_fl;
  logic r_ss_d, r_sclk_d, r_armed, r_pend, r_loaded, r_err;
  logic [6:0] r_cnt;
  logic [N-1:0] r_sh, r_stage;
  logic [W-1:0] r_px, r_py, r_fx, r_fy, r_vx, r_vy;
  logic w_ss, w_rise, w_ss_up, w_shift, w_done, w_bad, w_commit;
  assign w_ss = r_ss_s[1];
  assign w_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_ss_up = w_ss & ~r_ss_d;
  assign w_shift = r_armed & ~w_ss & w_rise;
  assign w_done = w_ss_up & (r_cnt == FULL);
  assign w_bad = w_ss_up & (r_cnt != FULL) & (r_cnt != '0);
  assign w_commit = i_load & r_pend;
  // r_armed stays low until ss_n has been seen high from the real pin, so a select
  // already in progress at reset release is never shifted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_s <= 2'b11;
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_fl <= '0;
      r_ss_d <= 1'b1;
      r_sclk_d <= 1'b0;
      r_armed <= 1'b0;
      r_cnt <= '0;
      r_sh <= '0;
      r_stage <= '0;
      r_pend <= 1'b0;
      r_loaded <= 1'b0;
      r_err <= 1'b0;
      {r_px, r_py, r_fx, r_fy, r_vx, r_vy} <= {RST_PX, RST_PY, RST_FX, RST_FY, RST_VX, RST_VY};
    end else begin
      r_ss_s <= {r_ss_s[0], i_ss_n};
      r_sclk_s <= {r_sclk_s[0], i_sclk};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_fl <= r_fl + 2'(r_fl != 2'd2);
      r_ss_d <= w_ss;
      r_sclk_d <= r_sclk_s[1];
      r_armed <= r_armed | ((r_fl == 2'd2) & w_ss);
      r_cnt <= w_ss ? '0 : (w_shift && r_cnt != SAT) ? r_cnt + 7'd1 : r_cnt;
      if (w_shift) r_sh <= {r_sh[N-2:0], r_mosi_s[1]};
      if (w_done) r_stage <= r_sh;
      r_pend <= w_done | (r_pend & ~w_commit);
      r_loaded <= w_commit;
      r_err <= w_bad;
      if (w_commit) {r_px, r_py, r_fx, r_fy, r_vx, r_vy} <= r_stage;
    end
  end
  assign {o_px, o_py, o_fx, o_fy, o_vx, o_vy} = {r_px, r_py, r_fx, r_fy, r_vx, r_vy};
  assign o_pending = r_pend;
  assign o_loaded = r_loaded;
  assign o_err = r_err;
endmodule

// File: tb/tb_pov_loader.sv
// tb_pov_loader: directed checks of SPI staging, commit, error and reset behaviour
module tb_pov_loader;
  logic clk = 1'b0, reset = 1'b1, i_ss_n = 1'b1, i_sclk = 1'b0, i_mosi = 1'b0, i_load = 1'b0;
  logic [15:0] o_px, o_py, o_fx, o_fy, o_vx, o_vy;
  logic o_pending, o_loaded, o_err;
  logic [95:0] w_act;
  int checks = 0, errors = 0, n_err = 0, n_ld = 0;
  localparam logic [95:0] RSTV = 96'h0600_0600_0400_0000_0000_FE00;
  localparam logic [95:0] F1 = 96'h0800_0A00_0000_0400_FD00_0000;
  localparam logic [95:0] FA = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [95:0] FB = 96'h0123_4567_89AB_CDEF_8001_7FFE;
  localparam logic [95:0] FC = 96'hA5A5_5A5A_0F0F_F0F0_00FF_FF00;
  localparam logic [95:0] FD = 96'h7777_0001_8000_1234_4321_BEEF;
  pov_loader dut (
    .clk(clk), .reset(reset), .i_ss_n(i_ss_n), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_load(i_load),
    .o_px(o_px), .o_py(o_py), .o_fx(o_fx), .o_fy(o_fy), .o_vx(o_vx), .o_vy(o_vy),
    .o_pending(o_pending), .o_loaded(o_loaded), .o_err(o_err)
  );
  assign w_act = {o_px, o_py, o_fx, o_fy, o_vx, o_vy};
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (o_err) n_err++;
    if (o_loaded) n_ld++;
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_bits(input logic [95:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      i_mosi = (i < 96) ? d[95 - (i % 96)] : 1'b0;
      wait_clk(5);
      i_sclk = 1'b1;
      wait_clk(5);
      i_sclk = 1'b0;
    end
  endtask
  task automatic spi(input logic [95:0] d, input int n, input logic ld_at_end);
    i_ss_n = 1'b0;
    wait_clk(5);
    spi_bits(d, n);
    wait_clk(5);
    i_ss_n = 1'b1;
    if (ld_at_end) begin
      wait_clk(2);
      i_load = 1'b1;
      wait_clk(1);
      i_load = 1'b0;
    end
    wait_clk(8);
  endtask
  task automatic commit();
    i_load = 1'b1;
    wait_clk(1);
    i_load = 1'b0;
    wait_clk(3);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    checks++;
    if (w_act !== RSTV) begin errors++; $display("FAIL reset_outputs got %h want %h", w_act, RSTV); end
    checks++;
    if (o_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", o_pending); end
    checks++;
    if (o_loaded !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", o_loaded, o_err); end
  endtask
  task automatic test_frame();
    int l0;
    spi(F1, 96, 1'b0);
    checks++;
    if (o_pending !== 1'b1) begin errors++; $display("FAIL frame_pending got %b want 1", o_pending); end
    checks++;
    if (w_act !== RSTV) begin errors++; $display("FAIL frame_hold got %h want %h", w_act, RSTV); end
    l0 = n_ld;
    commit();
    checks++;
    if (w_act !== F1) begin errors++; $display("FAIL frame_commit got %h want %h", w_act, F1); end
    checks++;
    if (n_ld - l0 !== 1) begin errors++; $display("FAIL frame_loaded_pulses got %0d want 1", n_ld - l0); end
    checks++;
    if (o_pending !== 1'b0) begin errors++; $display("FAIL frame_pending_clear got %b want 0", o_pending); end
    l0 = n_ld;
    commit();
    checks++;
    if (w_act !== F1 || n_ld != l0) begin errors++; $display("FAIL load_no_pending got %h/%0d want %h/0", w_act, n_ld - l0, F1); end
  endtask
  task automatic test_bad_len();
    int e0;
    e0 = n_err;
    spi(FA, 95, 1'b0);
    checks++;
    if (n_err - e0 !== 1 || o_pending !== 1'b0) begin errors++; $display("FAIL short95 err %0d pend %b want 1 0", n_err - e0, o_pending); end
    e0 = n_err;
    spi(FA, 97, 1'b0);
    checks++;
    if (n_err - e0 !== 1 || o_pending !== 1'b0) begin errors++; $display("FAIL long97 err %0d pend %b want 1 0", n_err - e0, o_pending); end
    spi(FA, 96, 1'b0);
    e0 = n_err;
    spi(FB, 95, 1'b0);
    checks++;
    if (n_err - e0 !== 1 || o_pending !== 1'b1) begin errors++; $display("FAIL short_pending err %0d pend %b want 1 1", n_err - e0, o_pending); end
    commit();
    checks++;
    if (w_act !== FA) begin errors++; $display("FAIL staging_untouched got %h want %h", w_act, FA); end
    e0 = n_err;
    spi(FB, 0, 1'b0);
    checks++;
    if (n_err != e0 || o_pending !== 1'b0) begin errors++; $display("FAIL empty_select err %0d pend %b want 0 0", n_err - e0, o_pending); end
  endtask
  task automatic test_back_to_back();
    spi(FA, 96, 1'b0);
    spi(FB, 96, 1'b0);
    checks++;
    if (o_pending !== 1'b1 || w_act !== FA) begin errors++; $display("FAIL b2b_stage pend %b act %h want 1 %h", o_pending, w_act, FA); end
    commit();
    checks++;
    if (w_act !== FB) begin errors++; $display("FAIL b2b_commit got %h want %h", w_act, FB); end
  endtask
  task automatic test_coincident();
    int l0;
    l0 = n_ld;
    spi(FC, 96, 1'b1);
    checks++;
    if (w_act !== FB || n_ld != l0) begin errors++; $display("FAIL coincident_hold act %h ld %0d want %h 0", w_act, n_ld - l0, FB); end
    checks++;
    if (o_pending !== 1'b1) begin errors++; $display("FAIL coincident_pending got %b want 1", o_pending); end
    commit();
    checks++;
    if (w_act !== FC || n_ld - l0 !== 1) begin errors++; $display("FAIL coincident_next act %h ld %0d want %h 1", w_act, n_ld - l0, FC); end
  endtask
  task automatic test_reset_mid();
    int e0;
    e0 = n_err;
    i_ss_n = 1'b0;
    wait_clk(5);
    spi_bits(FA, 40);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
    checks++;
    if (w_act !== RSTV || o_pending !== 1'b0) begin errors++; $display("FAIL midreset_state act %h pend %b want %h 0", w_act, o_pending, RSTV); end
    spi_bits(FB, 96);
    wait_clk(5);
    i_ss_n = 1'b1;
    wait_clk(8);
    checks++;
    if (o_pending !== 1'b0 || n_err != e0) begin errors++; $display("FAIL no_fresh_fall pend %b err %0d want 0 0", o_pending, n_err - e0); end
    spi(FD, 96, 1'b0);
    checks++;
    if (o_pending !== 1'b1 || n_err != e0) begin errors++; $display("FAIL midreset_frame pend %b err %0d want 1 0", o_pending, n_err - e0); end
    commit();
    checks++;
    if (w_act !== FD) begin errors++; $display("FAIL midreset_commit got %h want %h", w_act, FD); end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_bad_len();
    test_back_to_back();
    test_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
